uart_cmd_sequencer: RTL and testbench
=====================================

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter HEADER, default 8'h68 ("h"), the command start byte.
REQ-002 SHALL have parameter TIMEOUT, default 16'd1000, the maximum number of clk cycles allowed between operand bytes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8 bits: received UART byte, valid when new_rx_data=1.
REQ-006 SHALL have port new_rx_data, input, 1 bit: one-cycle strobe, rx_data valid.
REQ-007 SHALL have port tx_data, output, 8 bits: byte to transmit.
REQ-008 SHALL have port new_tx_data, output, 1 bit: one-cycle strobe, tx_data valid.
REQ-009 SHALL have port tx_busy, input, 1 bit: UART transmitter busy.
REQ-010 SHALL have port op_data, output, 32 bits: assembled operand to the compute datapath.
REQ-011 SHALL have port op_start, output, 1 bit: one-cycle start strobe to the datapath.
REQ-012 SHALL have port op_done, input, 1 bit: datapath result-valid strobe.
REQ-013 SHALL have port op_result, input, 32 bits: datapath result, sampled when op_done=1.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on an inter-byte timeout.
REQ-016 SHALL have port ovr, output, 1 bit: sticky flag, set when a byte is dropped.

Function
REQ-017 SHALL implement states IDLE, RX_OPERAND, START, WAIT_DONE, TX_BYTE, TX_WAIT.
REQ-018 IDLE: on new_rx_data with rx_data==HEADER SHALL clear the byte count and timer and go to RX_OPERAND; SHALL silently ignore any other byte.
REQ-019 RX_OPERAND: SHALL shift each strobed byte in MSB-first (first byte lands in op_data[31:24]); a HEADER-valued byte here is data.
REQ-020 On the 4th operand byte SHALL go to START; op_data SHALL be stable from then until the next HEADER is accepted.
REQ-021 Timer SHALL reset on every operand byte; on reaching TIMEOUT cycles without a byte, SHALL discard the partial operand, pulse err, and return to IDLE.
REQ-022 START: SHALL assert op_start for exactly one cycle (the cycle after the 4th byte is registered), then go to WAIT_DONE.
REQ-023 WAIT_DONE: SHALL latch op_result on op_done, then go to TX_BYTE; op_done SHALL be ignored in every other state.
REQ-024 TX_BYTE: while tx_busy=1 SHALL hold; when tx_busy=0 SHALL drive tx_data and pulse new_tx_data for one cycle, then go to TX_WAIT.
REQ-025 Result bytes SHALL be sent MSB first: [31:24], [23:16], [15:8], [7:0].
REQ-026 TX_WAIT: SHALL stay at least one cycle, and until tx_busy=0; then go to TX_BYTE, or to IDLE after the 4th byte.
REQ-027 new_rx_data in START, WAIT_DONE, TX_BYTE or TX_WAIT SHALL drop the byte and set ovr.
REQ-028 new_tx_data SHALL never be high in two consecutive cycles.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE and clear byte count and timer.
REQ-030 rst=0 SHALL immediately clear tx_data, new_tx_data, op_data, op_start, busy, err and ovr to 0.
REQ-031 rst asserted mid-transaction SHALL abort it with no further strobes; after release, the next transaction SHALL begin only on a new HEADER.

Verification
REQ-032 Basic: bytes 68,B1,00,00,00 (10-cycle spacing) -> op_data=32'hB1000000, single op_start pulse; op_done with op_result=32'h12345678 -> tx bytes 12,34,56,78, busy low afterwards.
REQ-033 Junk filter: bytes 41,39,68,01,FF,FF,FF -> op_data=32'h01FFFFFF, one op_start, err=0.
REQ-034 Timeout: bytes 68,AA then silence of TIMEOUT cycles -> one err pulse, no op_start, state IDLE; a following 68,00,00,00,01 -> op_data=32'h00000001.
REQ-035 TX backpressure: hold tx_busy=1 for 50 cycles after each new_tx_data -> exactly 4 strobes, none while tx_busy=1, none back-to-back.
REQ-036 Overrun/reset: a byte sent during WAIT_DONE -> ovr=1 and operand unchanged; rst=0 after the 2nd tx byte -> all outputs 0, no further new_tx_data, ovr=0.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sequencer
// Brief    : Collects a HEADER-prefixed 4-byte operand from a UART receiver,
//            starts one datapath operation and returns the 32-bit result
//            over the UART transmitter, most significant byte first.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_sequencer #(
    parameter logic [7:0]  HEADER  = 8'h68,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic [31:0] op_data,
    output logic        op_start,
    input  logic        op_done,
    input  logic [31:0] op_result,
    output logic        busy,
    output logic        err,
    output logic        ovr
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX_OPERAND = 3'd1,
        START      = 3'd2,
        WAIT_DONE  = 3'd3,
        TX_BYTE    = 3'd4,
        TX_WAIT    = 3'd5
    } state_t;

    state_t      state_q,   state_d;
    logic [2:0]  cnt_q,     cnt_d;
    logic [15:0] timer_q,   timer_d;
    logic [31:0] op_data_q, op_data_d;
    logic [31:0] result_q,  result_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        new_tx_q,  new_tx_d;
    logic        err_q,     err_d;
    logic        ovr_q,     ovr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            timer_q   <= 16'd0;
            op_data_q <= 32'd0;
            result_q  <= 32'd0;
            tx_data_q <= 8'd0;
            new_tx_q  <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            op_data_q <= op_data_d;
            result_q  <= result_d;
            tx_data_q <= tx_data_d;
            new_tx_q  <= new_tx_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        op_data_d = op_data_q;
        result_d  = result_q;
        tx_data_d = tx_data_q;
        new_tx_d  = 1'b0;
        err_d     = 1'b0;
        ovr_d     = ovr_q;

        case (state_q)
            IDLE: begin
                if (new_rx_data && (rx_data == HEADER)) begin
                    cnt_d   = 3'd0;
                    timer_d = 16'd0;
                    state_d = RX_OPERAND;
                end
            end

            RX_OPERAND: begin
                // timer_q counts silent edges since the last accepted byte
                if (new_rx_data) begin
                    op_data_d = {op_data_q[23:0], rx_data};
                    timer_d   = 16'd0;
                    if (cnt_q == 3'd3) begin
                        cnt_d   = 3'd0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (timer_q == (TIMEOUT - 16'd1)) begin
                    op_data_d = 32'd0;
                    err_d     = 1'b1;
                    cnt_d     = 3'd0;
                    timer_d   = 16'd0;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            START: begin
                state_d = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (op_done) begin
                    result_d = op_result;
                    cnt_d    = 3'd0;
                    state_d  = TX_BYTE;
                end
            end

            TX_BYTE: begin
                // result_q shifts left so the next byte is always in [31:24]
                if (!tx_busy) begin
                    tx_data_d = result_q[31:24];
                    result_d  = {result_q[23:0], 8'h00};
                    new_tx_d  = 1'b1;
                    cnt_d     = cnt_q + 3'd1;
                    state_d   = TX_WAIT;
                end
            end

            TX_WAIT: begin
                if (!tx_busy) begin
                    state_d = (cnt_q == 3'd4) ? IDLE : TX_BYTE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_rx_data && (state_q inside {START, WAIT_DONE, TX_BYTE, TX_WAIT})) begin
            ovr_d = 1'b1;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign op_data     = op_data_q;
    assign op_start    = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign err         = err_q;
    assign ovr         = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_sequencer
// Brief    : Self-checking bench for uart_cmd_sequencer: vector table, random
//            transactions against a transaction-level model, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_sequencer;

    localparam logic [7:0] HDR = 8'h68;
    localparam int         TO  = 64;

    typedef struct {
        int          n;
        logic [7:0]  b [8];
        logic [31:0] res;
        logic [31:0] exp_op;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic [31:0] op_data;
    logic        op_start;
    logic        op_done;
    logic [31:0] op_result;
    logic        busy;
    logic        err;
    logic        ovr;

    uart_cmd_sequencer #(
        .HEADER  (HDR),
        .TIMEOUT (16'(TO))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .op_data     (op_data),
        .op_start    (op_start),
        .op_done     (op_done),
        .op_result   (op_result),
        .busy        (busy),
        .err         (err),
        .ovr         (ovr)
    );

    always #5 clk = ~clk;

    int          n_checks    = 0;
    int          n_pass      = 0;
    int          hold_cycles = 2;
    int          busy_left   = 0;
    logic        prev_ntx    = 1'b0;
    logic [7:0]  txq [$];
    int          starts      = 0;
    int          errs        = 0;
    logic [31:0] op_at_start = 32'd0;
    vec_t        vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // One clock: sample just after the edge, then play the UART transmitter.
    task automatic tick();
        @(posedge clk);
        #1;
        if (new_tx_data === 1'b1) begin
            check("ntx_back_to_back", 32'(prev_ntx), 32'd0);
            check("ntx_while_busy", 32'(tx_busy), 32'd0);
            txq.push_back(tx_data);
            busy_left = hold_cycles;
        end
        prev_ntx = new_tx_data;
        if (op_start === 1'b1) begin
            starts++;
            op_at_start = op_data;
        end
        if (err === 1'b1) errs++;
        if (busy_left > 0) begin
            tx_busy = 1'b1;
            busy_left--;
        end else begin
            tx_busy = 1'b0;
        end
    endtask

    task automatic clear_obs();
        starts = 0;
        errs   = 0;
        txq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle_after);
        rx_data     = b;
        new_rx_data = 1'b1;
        tick();
        new_rx_data = 1'b0;
        repeat (idle_after) tick();
    endtask

    task automatic finish_op(input logic [31:0] res, input int delay);
        repeat (delay) tick();
        op_result = res;
        op_done   = 1'b1;
        tick();
        op_done   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
    endtask

    task automatic check_tx(input logic [31:0] res);
        logic [31:0] g;
        logic [31:0] e;
        check("tx_count", 32'(txq.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            g = (k < txq.size()) ? {24'd0, txq[k]} : 'x;
            e = (res >> (24 - 8 * k)) & 32'hFF;
            check($sformatf("tx_byte%0d", k), g, e);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idle, input int done_delay);
        clear_obs();
        for (int i = 0; i < v.n; i++) send_byte(v.b[i], idle);
        finish_op(v.res, done_delay);
        wait_idle(2000);
        check("op_data", op_data, v.exp_op);
        check("op_data_at_start", op_at_start, v.exp_op);
        check("op_start_pulses", 32'(starts), 32'd1);
        check("err_pulses", 32'(errs), 32'd0);
        check("ovr_clear", 32'(ovr), 32'd0);
        check_tx(v.res);
    endtask

    // Random transaction; expectations come from the byte-level protocol rules.
    task automatic rand_txn();
        int          nj;
        int          k;
        int          extra;
        bit          to_case;
        logic [7:0]  b;
        logic [7:0]  ops [4];
        logic [31:0] res;
        logic [31:0] exp_op;
        logic [7:0]  expq [$];
        clear_obs();
        hold_cycles = $urandom_range(0, 6);
        nj          = $urandom_range(0, 2);
        to_case     = ($urandom_range(0, 3) == 0);
        k           = to_case ? $urandom_range(0, 3) : 4;
        extra       = $urandom_range(0, 5);
        for (int j = 0; j < 4; j++) ops[j] = 8'($urandom);
        for (int j = 0; j < nj; j++) begin
            do b = 8'($urandom); while (b == HDR);
            send_byte(b, $urandom_range(0, 3));
        end
        send_byte(HDR, (k == 0) ? TO + extra : $urandom_range(0, TO - 1));
        for (int j = 0; j < k; j++) begin
            if (j == k - 1) send_byte(ops[j], to_case ? TO + extra : 0);
            else            send_byte(ops[j], $urandom_range(0, TO - 1));
        end
        if (to_case) begin
            check("rand_to_err", 32'(errs), 32'd1);
            check("rand_to_no_start", 32'(starts), 32'd0);
            check("rand_to_idle", 32'(busy), 32'd0);
            check("rand_to_no_tx", 32'(txq.size()), 32'd0);
        end else begin
            exp_op = 32'd0;
            for (int j = 0; j < 4; j++) exp_op = (exp_op << 8) | 32'(ops[j]);
            res = $urandom;
            for (int j = 0; j < 4; j++) expq.push_back(8'(res >> (24 - 8 * j)));
            finish_op(res, $urandom_range(1, 10));
            wait_idle(2000);
            check("rand_op_data", op_data, exp_op);
            check("rand_start_pulses", 32'(starts), 32'd1);
            check("rand_err", 32'(errs), 32'd0);
            check("rand_tx_count", 32'(txq.size()), 32'(expq.size()));
            for (int j = 0; j < 4; j++)
                check("rand_tx_byte", (j < txq.size()) ? {24'd0, txq[j]} : 'x, {24'd0, expq[j]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_new_tx"}, 32'(new_tx_data), 32'd0);
        check({tag, "_op_data"}, op_data, 32'd0);
        check({tag, "_op_start"}, 32'(op_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_ovr"}, 32'(ovr), 32'd0);
    endtask

    initial begin
        int   n;
        vec_t v;

        vecs[0] = '{5, '{8'h68, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 32'h12345678, 32'hB1000000};
        vecs[1] = '{7, '{8'h41, 8'h39, 8'h68, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00}, 32'hA5A50F0F, 32'h01FFFFFF};
        vecs[2] = '{5, '{8'h68, 8'h68, 8'h68, 8'h68, 8'h68, 8'h00, 8'h00, 8'h00}, 32'h00000000, 32'h68686868};
        vecs[3] = '{5, '{8'h68, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00}, 32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[4] = '{7, '{8'h00, 8'hFF, 8'h68, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00}, 32'h80000001, 32'h00000001};

        rst         = 1'b0;
        rx_data     = 8'd0;
        new_rx_data = 1'b0;
        tx_busy     = 1'b0;
        op_done     = 1'b0;
        op_result   = 32'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 9, 3);

        // Inter-byte gap of TIMEOUT-1 silent cycles is still accepted
        clear_obs();
        send_byte(HDR, TO - 1);
        send_byte(8'h11, TO - 1);
        send_byte(8'h22, TO - 1);
        send_byte(8'h33, TO - 1);
        send_byte(8'h44, 0);
        check("gap_limit_no_err", 32'(errs), 32'd0);
        check("gap_limit_start", 32'(starts), 32'd1);
        finish_op(32'hCAFEF00D, 2);
        wait_idle(2000);
        check("gap_limit_op", op_data, 32'h11223344);
        check_tx(32'hCAFEF00D);

        // Timeout after exactly TIMEOUT silent cycles
        clear_obs();
        send_byte(HDR, 0);
        send_byte(8'hAA, TO - 1);
        check("timeout_not_early", 32'(errs), 32'd0);
        tick();
        check("timeout_err_now", 32'(err), 32'd1);
        tick();
        check("timeout_err_one_cycle", 32'(err), 32'd0);
        check("timeout_err_pulses", 32'(errs), 32'd1);
        check("timeout_no_start", 32'(starts), 32'd0);
        check("timeout_idle", 32'(busy), 32'd0);
        v = '{5, '{8'h68, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, 32'h0BADF00D, 32'h00000001};
        run_vec(v, 2, 1);

        // Transmitter backpressure
        hold_cycles = 50;
        run_vec(vecs[0], 2, 3);

        // Overrun during WAIT_DONE, then reset after the second tx byte
        hold_cycles = 5;
        clear_obs();
        send_byte(HDR, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        send_byte(8'h04, 0);
        tick();
        send_byte(8'h55, 0);
        check("ovr_set", 32'(ovr), 32'd1);
        check("ovr_operand_kept", op_data, 32'h01020304);
        finish_op(32'h9ABCDEF0, 1);
        n = 0;
        while (txq.size() < 2 && n < 500) begin
            tick();
            n++;
        end
        check("two_bytes_before_reset", 32'(txq.size()), 32'd2);
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) tick();
        rst = 1'b1;
        repeat (120) tick();
        check("no_tx_after_reset", 32'(txq.size()), 32'd2);
        check("idle_after_reset", 32'(busy), 32'd0);
        check("ovr_after_reset", 32'(ovr), 32'd0);
        send_byte(8'h01, 2);
        send_byte(8'h02, 2);
        send_byte(8'h03, 2);
        send_byte(8'h04, 10);
        check("no_start_without_header", 32'(starts), 32'd1);
        check("idle_without_header", 32'(busy), 32'd0);
        hold_cycles = 2;
        run_vec(vecs[3], 1, 2);

        for (int t = 0; t < 24; t++) rand_txn();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
